// File: rtl/store_ctrl_pkg.sv
// Shared definitions for the store retirement sequencer: FSM encoding and
// queue-entry field positions derived from the tag/address widths.
package store_ctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_POP} state_t;

  // Entry layout, MSB->LSB: {A, val, addr, V, D, tag}
  function automatic int fld_d(input int wt);
    return wt;
  endfunction

  function automatic int fld_v(input int wt);
    return wt + 1;
  endfunction

  function automatic int fld_addr_lo(input int wt);
    return wt + 2;
  endfunction

  function automatic int fld_val(input int wt, input int wa);
    return wt + wa + 2;
  endfunction

  function automatic int fld_a(input int wt, input int wa);
    return wt + wa + 3;
  endfunction

endpackage

// File: rtl/store_commit_cnt.sv
// Saturating up/down count of committed-but-unwritten stores, with a sticky
// overflow flag when a commit arrives while already full.
module store_commit_cnt #(
  parameter int WIDTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           inc,
  input  logic           dec,
  output logic [WIDTH:0] cnt,
  output logic           err
);

  localparam logic [WIDTH:0] SIZE = {1'b1, {WIDTH{1'b0}}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (inc && !dec) begin
        if (cnt == SIZE) err <= 1'b1;
        else             cnt <= cnt + 1'b1;
      end else if (dec && !inc && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_commit_ctrl.sv
// Store address queue retirement: writes committed, resolved head entries to
// memory via req/gnt/done, drains killed entries, then pops the head.
module store_commit_ctrl
  import store_ctrl_pkg::*;
#(
  parameter int WIDTH_TAG  = 5,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH      = 4,
  parameter int WIDTH_DATA = 4 + WIDTH_ADDR + WIDTH_TAG
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WIDTH_DATA-1:0] i_entry,
  input  logic                  i_empty,
  output logic                  o_re,
  input  logic                  i_commit,
  output logic                  o_mem_req,
  output logic [WIDTH_ADDR-1:0] o_mem_addr,
  output logic [WIDTH_TAG-1:0]  o_mem_tag,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_done,
  output logic                  o_busy,
  output logic                  o_err
);

  localparam int A_BIT   = fld_a(WIDTH_TAG, WIDTH_ADDR);
  localparam int VAL_BIT = fld_val(WIDTH_TAG, WIDTH_ADDR);
  localparam int ADDR_LO = fld_addr_lo(WIDTH_TAG);
  localparam int V_BIT   = fld_v(WIDTH_TAG);
  localparam int D_BIT   = fld_d(WIDTH_TAG);

  logic                  e_a, e_val, e_v, e_d;
  logic [WIDTH_ADDR-1:0] e_addr;
  logic [WIDTH_TAG-1:0]  e_tag;
  logic                  head_ok;

  assign e_a     = i_entry[A_BIT];
  assign e_val   = i_entry[VAL_BIT];
  assign e_addr  = i_entry[ADDR_LO +: WIDTH_ADDR];
  assign e_v     = i_entry[V_BIT];
  assign e_d     = i_entry[D_BIT];
  assign e_tag   = i_entry[WIDTH_TAG-1:0];
  assign head_ok = !i_empty && e_a;

  state_t         state;
  logic           pop_val;
  logic [WIDTH:0] cnt;

  store_commit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .inc     (i_commit),
    .dec     (state == ST_POP && pop_val),
    .cnt     (cnt),
    .err     (o_err)
  );

  // Outputs are registered alongside the state so nothing is combinational
  // from inputs; pop_val remembers whether the popped entry owes a decrement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      pop_val    <= 1'b0;
      o_re       <= 1'b0;
      o_mem_req  <= 1'b0;
      o_busy     <= 1'b0;
      o_mem_addr <= '0;
      o_mem_tag  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (head_ok && !e_val) begin
            state   <= ST_POP;
            pop_val <= 1'b0;
            o_re    <= 1'b1;
            o_busy  <= 1'b1;
          end else if (head_ok && e_v && e_d && cnt != '0) begin
            state      <= ST_REQ;
            pop_val    <= 1'b1;
            o_mem_req  <= 1'b1;
            o_busy     <= 1'b1;
            o_mem_addr <= e_addr;
            o_mem_tag  <= e_tag;
          end
        end
        ST_REQ: begin
          if (i_mem_gnt) begin
            state     <= ST_WAIT;
            o_mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_mem_done) begin
            state <= ST_POP;
            o_re  <= 1'b1;
          end
        end
        ST_POP: begin
          state  <= ST_IDLE;
          o_re   <= 1'b0;
          o_busy <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          o_re      <= 1'b0;
          o_mem_req <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/store_commit_ctrl.md
# store_commit_ctrl

Retirement sequencer for the store address queue in the AGU. It watches the queue head entry and counts stores committed by the ROB. It writes each committed, fully resolved store to the data-memory port over a req/gnt/done handshake, then pops the queue head. Killed entries (val=0) are drained without a memory access.

## Interface
- WIDTH_TAG, 5: ROB tag width.
- WIDTH_ADDR, 32: store address width.
- WIDTH, 4: queue index width; SIZE = 2**WIDTH entries.
- WIDTH_DATA, 4+WIDTH_ADDR+WIDTH_TAG: queue entry width.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_entry  in  WIDTH_DATA  queue head entry, MSB→LSB: {A, val, addr, V, D, tag}.
- i_empty  in  1  queue empty.
- o_re  out  1  pop queue head; one-cycle pulse.
- i_commit  in  1  ROB commits one store this cycle; pulse, in program order.
- o_mem_req  out  1  memory write request.
- o_mem_addr  out  WIDTH_ADDR  store address, latched.
- o_mem_tag  out  WIDTH_TAG  store tag, latched; the store-data queue uses it to supply data.
- i_mem_gnt  in  1  request accepted.
- i_mem_done  in  1  write complete.
- o_busy  out  1  state ≠ IDLE.
- o_err  out  1  sticky: commit counter overflow.

## Operation
- Field decode:
  - A = bit WIDTH_DATA-1.
  - val = bit WIDTH_DATA-2.
  - addr = bits [WIDTH_TAG+2+WIDTH_ADDR-1 : WIDTH_TAG+2].
  - V = bit WIDTH_TAG+1.
  - D = bit WIDTH_TAG.
  - tag = bits [WIDTH_TAG-1:0].
- head_ok = !i_empty & A.
- Commit counter cnt:
  - Width WIDTH+1, range 0..SIZE.
  - +1 on i_commit.
  - −1 on the POP of a valid (val=1) entry.
  - Simultaneous +1/−1 leaves cnt unchanged.
  - i_commit while cnt==SIZE and no decrement: cnt holds, o_err set until reset.
- FSM states:
  - IDLE:
    - head_ok & !val → POP; killed entry, no memory access, cnt untouched.
    - head_ok & val & V & D & cnt>0 → REQ; latch addr→o_mem_addr, tag→o_mem_tag.
    - Otherwise stay. This includes A=0 with !i_empty, V=0, D=0, or cnt==0.
  - REQ: o_mem_req=1; on i_mem_gnt → WAIT. Address and tag are held stable.
  - WAIT: on i_mem_done → POP. i_mem_done is ignored outside WAIT.
  - POP: o_re=1 for exactly this cycle; decrement cnt if the popped entry was valid; → IDLE.
- A committed store is never cancelled once it reaches REQ.
- The controller never asserts o_re while i_empty=1.

## Timing
- Reset values:
  - state IDLE, cnt 0.
  - o_re, o_mem_req, o_busy, o_err all 0.
  - o_mem_addr, o_mem_tag 0.
- All outputs are registered or decoded from the state only; none depends combinationally on inputs.
- Valid store path:
  - Head ready and cnt>0 sampled in IDLE at cycle N → o_mem_req=1 from N+1.
  - gnt sampled at cycle G → WAIT at G+1.
  - done sampled at cycle K → o_re=1 at K+1 → IDLE at K+2.
  - Best case, gnt at N+1 and done at N+2: 4 cycles per store.
- Killed entry: o_re at N+1, IDLE at N+2; 2 cycles per killed entry.
- The queue updates its head one cycle after o_re; IDLE re-evaluates i_entry at K+2.
- i_commit is counted in every state, including the same cycle as POP.
- Asynchronous reset mid-transaction: immediate return to IDLE with all reset values. The memory side must discard any outstanding request.

## Structure
- Shared package store_ctrl_pkg holds:
  - state encoding (IDLE, REQ, WAIT, POP);
  - field bit-offset constants derived from WIDTH_TAG and WIDTH_ADDR.
- One sub-module: store_commit_cnt. It is the saturating up/down counter with overflow flag, parameterised by WIDTH.
- The FSM and output latches live in the top module.

## Test plan
- Single store: push {A=1,val=1,addr=0x100,V=1,D=1,tag=3}, one i_commit, gnt one cycle after req, done two cycles later → o_mem_addr=0x100, o_mem_tag=3, one o_re pulse at done+1, cnt returns to 0.
- Commit before data: head D=0 with cnt=1 → no req. Set D → req on the next cycle.
- Killed entry: head val=0, cnt=0 → o_re pulse, no o_mem_req, cnt stays 0. The next valid entry then proceeds normally.
- Back-to-back stores: 3 entries, 3 commits; one commit lands in a POP cycle → cnt 3→2→1→0 with no lost count; three writes in queue order.
- Overflow: 2**WIDTH+1 commits with no done → cnt=SIZE, o_err=1 and sticky.
- Reset in WAIT: assert i_rst_n=0 → all outputs 0 immediately, state IDLE, cnt 0 after release.
